// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ requesters, returns results in issue order.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
package alu;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_cmd_t;

  typedef struct packed {
    alu_cmd_t              cmd;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_task_t;
endpackage

module alu_arbiter
  import alu::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  alu_task_t [NUM_REQ-1:0]            req_task_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               alu_valid_o,
  output alu_task_t                          alu_task_o,
  input  logic                               alu_ready_i,
  input  logic                               alu_res_valid_i,
  input  logic [DATA_WIDTH-1:0]              alu_res_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [DATA_WIDTH-1:0]              rsp_data_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt_o,
  output logic                               err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } slot_state_t;

  slot_state_t      state;
  logic [IW-1:0]    win;
  logic [NUM_REQ-1:0] grant;
  logic             found;
  logic             slot_free;
  logic             can_accept;
  logic             accept;
  logic             pop;

  logic [IW-1:0]    tag_q [MAX_OUTST];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  function automatic int rr_idx(input logic [IW-1:0] p, input int k);
    return (int'(p) + k) % NUM_REQ;
  endfunction

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid_i[rr_idx(rr_ptr, k)]) begin
        found = 1'b1;
        win   = IW'(rr_idx(rr_ptr, k));
        grant[rr_idx(rr_ptr, k)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid_i[k]) begin
        found    = 1'b1;
        win      = IW'(k);
        grant[k] = 1'b1;
      end
    end
  end
`endif

  // Full count blocks accept even if a result pops this cycle.
  assign slot_free   = (state == EMPTY) || alu_ready_i;
  assign can_accept  = slot_free && (cnt < CW'(MAX_OUTST));
  assign req_ready_o = can_accept ? grant : '0;
  assign accept      = |req_ready_o;
  assign pop         = alu_res_valid_i && (cnt != '0);
  assign outst_cnt_o = cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      alu_valid_o <= 1'b0;
      alu_task_o  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state       <= HOLD;
            alu_valid_o <= 1'b1;
            alu_task_o  <= req_task_i[win];
          end
        end
        HOLD: begin
          if (accept) begin
            alu_task_o  <= req_task_i[win];
          end else if (alu_ready_i) begin
            state       <= EMPTY;
            alu_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          alu_valid_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_q[wr_ptr] <= win;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      unique case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (pop) begin
        rsp_valid_o <= NUM_REQ'(1) << tag_q[rd_ptr];
        rsp_data_o  <= alu_res_i;
      end
      if (alu_res_valid_i && (cnt == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized run against a queue-based model.
// Works for both arbitration builds (ALU_ARBITER_ROUND_ROBIN_EN defined or not).
module tb_alu_arbiter;
  import alu::*;

  localparam int N = 4;
  localparam int M = 4;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  alu_task_t [N-1:0] req_task;
  logic [N-1:0]     req_ready;
  logic             alu_valid;
  alu_task_t        alu_task;
  logic             alu_ready;
  logic             res_valid;
  logic [15:0]      res;
  logic [N-1:0]     rsp_valid;
  logic [15:0]      rsp_data;
  logic [2:0]       outst;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .MAX_OUTST(M)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_task_i(req_task),
    .req_ready_o(req_ready),
    .alu_valid_o(alu_valid),
    .alu_task_o(alu_task),
    .alu_ready_i(alu_ready),
    .alu_res_valid_i(res_valid),
    .alu_res_i(res),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data),
    .outst_cnt_o(outst),
    .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_task  = '0;
    alu_ready = 1'b0;
    res_valid = 1'b0;
    res       = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic alu_task_t rnd_task();
    alu_task_t t;
    t.cmd = alu_cmd_t'($urandom_range(0, 7));
    t.a   = 16'($urandom);
    t.b   = 16'($urandom);
    return t;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({alu_valid, rsp_valid, outst, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: got v=%b rsp=%b cnt=%0d err=%b want all 0",
               alu_valid, rsp_valid, outst, err);
    end
    n_checks++;
    if ({alu_task, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got task=%h data=%h want 0", alu_task, rsp_data);
    end
  endtask

  task automatic test_single();
    alu_task_t t;
    do_reset();
    t = '{cmd: ALU_ADD, a: 16'd3, b: 16'd4};
    req_valid = 4'b0100;
    req_task[2] = t;
    alu_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (alu_valid !== 1'b1 || alu_task !== t || outst !== 3'd1) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b task=%h cnt=%0d want 1 %h 1",
               alu_valid, alu_task, outst, t);
    end
    tick();
    res_valid = 1'b1;
    res = 16'd7;
    tick();
    res_valid = 1'b0;
    res = 16'hdead;
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 16'd7 || outst !== 3'd0) begin
      n_fail++;
      $display("FAIL single_rsp: got rsp=%b data=%0d cnt=%0d want 0100 7 0",
               rsp_valid, rsp_data, outst);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'd7 || alu_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got rsp=%b data=%0d v=%b want 0000 7 0",
               rsp_valid, rsp_data, alu_valid);
    end
  endtask

  task automatic test_arbitration();
    int exp_w;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_task[i] = rnd_task();
    alu_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      res_valid = (k != 0);
      #1;
      exp_w = RR ? (k % N) : 0;
      n_checks++;
      if (req_ready !== N'(1) << exp_w) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got %b want idx %0d", k, req_ready, exp_w);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    alu_task_t t0;
    int w;
    do_reset();
    t0 = rnd_task();
    req_valid = 4'b0001;
    req_task[0] = t0;
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_task[i] = rnd_task();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (req_ready !== '0 || alu_valid !== 1'b1 || alu_task !== t0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b task=%h want 0 1 %h",
                 k, req_ready, alu_valid, alu_task, t0);
      end
      tick();
    end
    alu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      w = RR ? k + 1 : 0;
      n_checks++;
      if (req_ready !== N'(1) << w) begin
        n_fail++;
        $display("FAIL release_ready[%0d]: got %b want idx %0d", k, req_ready, w);
      end
      tick();
      n_checks++;
      if (alu_valid !== 1'b1 || alu_task !== req_task[w]) begin
        n_fail++;
        $display("FAIL release_task[%0d]: got v=%b %h want 1 %h",
                 k, alu_valid, alu_task, req_task[w]);
      end
    end
    n_checks++;
    if (outst !== 3'd4) begin
      n_fail++;
      $display("FAIL release_cnt: got %0d want 4", outst);
    end
    idle();
    tick();
  endtask

  task automatic test_full();
    int accepts;
    do_reset();
    accepts = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_task[i] = rnd_task();
    alu_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready != '0) accepts++;
      tick();
    end
    n_checks++;
    if (accepts !== M || outst !== 3'(M)) begin
      n_fail++;
      $display("FAIL full_count: got acc=%0d cnt=%0d want %0d %0d", accepts, outst, M, M);
    end
    res_valid = 1'b1;
    res = 16'h1234;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL full_bypass: got %b want 0000", req_ready);
    end
    tick();
    res_valid = 1'b0;
    n_checks++;
    if (outst !== 3'(M - 1) || rsp_valid !== 4'b0001 || rsp_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL full_pop: got cnt=%0d rsp=%b data=%h want %0d 0001 1234",
               outst, rsp_valid, rsp_data, M - 1);
    end
    #1;
    n_checks++;
    if (req_ready === '0) begin
      n_fail++;
      $display("FAIL full_resume: got %b want nonzero", req_ready);
    end
    tick();
    n_checks++;
    if (outst !== 3'(M)) begin
      n_fail++;
      $display("FAIL full_refill: got %0d want %0d", outst, M);
    end
    idle();
    tick();
  endtask

  task automatic test_error_and_reset();
    do_reset();
    res_valid = 1'b1;
    res = 16'h00aa;
    tick();
    res_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rsp_valid !== '0 || outst !== 3'd0) begin
      n_fail++;
      $display("FAIL err_set: got err=%b rsp=%b cnt=%0d want 1 0 0", err, rsp_valid, outst);
    end
    tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    do_reset();
    req_valid = 4'b0010;
    req_task[1] = rnd_task();
    alu_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    req_valid = '0;
    n_checks++;
    if (outst !== 3'd3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d err=%b want 3 0", outst, err);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (outst !== 3'd0 || alu_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d v=%b want 0 0", outst, alu_valid);
    end
    #1;
    rst = 1'b0;
    tick();
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL post_reset_err: got err=%b rsp=%b want 1 0", err, rsp_valid);
    end
  endtask

  task automatic test_random();
    int        tagq[$];
    bit        m_hold;
    alu_task_t m_task;
    bit        m_err;
    logic [N-1:0] m_rsp;
    logic [15:0]  m_data;
    int        rr;
    int        w;
    logic [N-1:0] exp_rdy;
    bit        pop;
    do_reset();
    m_hold = 0; m_task = '0; m_err = 0; m_rsp = '0; m_data = '0; rr = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_task[i] = rnd_task();
      alu_ready = ($urandom_range(0, 3) != 0);
      res_valid = ($urandom_range(0, 9) < 4);
      res = 16'($urandom);
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = RR ? (rr + k) % N : k;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      exp_rdy = '0;
      if ((!m_hold || alu_ready) && tagq.size() < M && w >= 0) exp_rdy = N'(1) << w;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rdy);
      end
      pop = res_valid && tagq.size() > 0;
      if (res_valid && tagq.size() == 0) m_err = 1;
      m_rsp = '0;
      if (pop) begin
        m_rsp = N'(1) << tagq.pop_front();
        m_data = res;
      end
      if (exp_rdy != '0) begin
        tagq.push_back(w);
        m_hold = 1;
        m_task = req_task[w];
        rr = (w + 1) % N;
      end else if (m_hold && alu_ready) begin
        m_hold = 0;
      end
      tick();
      n_checks++;
      if (alu_valid !== m_hold || (m_hold && alu_task !== m_task)) begin
        n_fail++;
        $display("FAIL rnd_issue[%0d]: got v=%b %h want %b %h",
                 c, alu_valid, alu_task, m_hold, m_task);
      end
      n_checks++;
      if (outst !== 3'(tagq.size()) || rsp_valid !== m_rsp
          || rsp_data !== m_data || err !== m_err) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got cnt=%0d rsp=%b d=%h e=%b want %0d %b %h %b",
                 c, outst, rsp_valid, rsp_data, err,
                 tagq.size(), m_rsp, m_data, m_err);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_arbitration();
    test_stall();
    test_full();
    test_error_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ALU (2..8).
REQ-002 SHALL have parameter MAX_OUTST, default 4, maximum issued-but-unanswered ALU tasks (1..8).
REQ-003 SHALL take task and data widths from package alu: alu_task_t, DATA_WIDTH = 16.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 req_valid_i  input  NUM_REQ  per-requester task valid.
REQ-007 req_task_i  input  NUM_REQ x alu_task_t  per-requester task {cmd, a, b}.
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 alu_valid_o  output  1  registered task valid toward ALU.
REQ-010 alu_task_o  output  alu_task_t  registered task toward ALU.
REQ-011 alu_ready_i  input  1  ALU accepts alu_task_o.
REQ-012 alu_res_valid_i  input  1  ALU result valid, results in issue order.
REQ-013 alu_res_i  input  DATA_WIDTH  ALU result.
REQ-014 rsp_valid_o  output  NUM_REQ  one-hot result strobe to owning requester.
REQ-015 rsp_data_o  output  DATA_WIDTH  result data, shared by all requesters.
REQ-016 outst_cnt_o  output  $clog2(MAX_OUTST+1)  tags currently held (issue slot plus in ALU).
REQ-017 err_o  output  1  sticky: result arrived with no outstanding tag.

Function
REQ-018 Issue slot FSM SHALL have states EMPTY (alu_valid_o=0) and HOLD (alu_valid_o=1); alu_valid_o/alu_task_o SHALL be stable while HOLD and alu_ready_i=0.
REQ-019 Slot SHALL be free when EMPTY, or HOLD with alu_ready_i=1 same cycle.
REQ-020 Accept SHALL occur only when slot free and outst_cnt_o < MAX_OUTST; then req_ready_o asserts combinationally for the single winner among req_valid_i.
REQ-021 On accept (req_valid_i[g] & req_ready_o[g]) the task SHALL load into the slot, next state HOLD, alu_valid_o high next cycle (1-cycle latency); index g SHALL be pushed into the tag FIFO (depth MAX_OUTST).
REQ-022 HOLD with alu_ready_i=1 and no accept SHALL go to EMPTY; with accept SHALL stay HOLD with new task (back-to-back, one task per cycle).
REQ-023 On alu_res_valid_i=1 with outst_cnt_o>0, head tag h SHALL pop; rsp_valid_o[h] and rsp_data_o=alu_res_i SHALL assert for exactly one cycle, registered, next cycle.
REQ-024 rsp_data_o SHALL hold last value when rsp_valid_o=0; no response backpressure exists.
REQ-025 On alu_res_valid_i=1 with outst_cnt_o=0: no pop, no rsp_valid_o, err_o set until reset.
REQ-026 Simultaneous accept and result SHALL push and pop same cycle; outst_cnt_o unchanged.
REQ-027 Full (outst_cnt_o=MAX_OUTST) SHALL block accept even if result pops that cycle (no bypass).
REQ-028 Tag FIFO pointers SHALL wrap modulo MAX_OUTST.

Reset
REQ-029 rst_i SHALL asynchronously force: slot EMPTY, alu_valid_o=0, alu_task_o=0 (cmd ALU_NOP), FIFO empty, outst_cnt_o=0, rsp_valid_o=0, rsp_data_o=0, err_o=0, round-robin pointer 0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; later results count as REQ-025 errors.

Configuration
REQ-031 Macro ALU_ARBITER_ROUND_ROBIN_EN defined: round-robin, search starts at index after last accepted requester, pointer updates only on accept.
REQ-032 Macro undefined: fixed priority, lowest index wins; no pointer state.

Verification
REQ-033 Single request: req_valid_i[2]=1, cmd ALU_ADD, a=3, b=4, ALU ready, result 7 two cycles later -> alu_valid_o next cycle, rsp_valid_o=0b0100, rsp_data_o=7.
REQ-034 All 4 requesting continuously, alu_ready_i=1 (RR build) -> accepts in order 0,1,2,3,0; fixed-priority build -> requester 0 only.
REQ-035 alu_ready_i=0 for 5 cycles with HOLD -> alu_task_o stable, req_ready_o all 0, then one transfer per cycle after release.
REQ-036 ALU withholds results, 6 requests pending, MAX_OUTST=4 -> exactly 4 accepts, outst_cnt_o=4, accept resumes cycle after first pop.
REQ-037 alu_res_valid_i=1 after reset with no issue -> err_o=1, rsp_valid_o=0; rst_i pulse during 3 outstanding -> outst_cnt_o=0, alu_valid_o=0 immediately.
